led_regs_axil_arbiter: RTL and testbench

//  Shares the single AXI-Lite slave port of the LED register block between
//  NUM_REQ internal requesters, e.g. a pattern sequencer and a debug UART bridge.

---
 rtl/led_regs_axil_arbiter_if.sv | 49 ++++
 rtl/led_regs_axil_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_led_regs_axil_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/led_regs_axil_arbiter_if.sv
// AXI-Lite bus between the arbiter and the LED register block.
// Single-word transfers; 32-bit data, ADDR_W-bit byte address.
interface led_regs_axil_arbiter_if #(
    parameter int ADDR_W = 21
);
    logic              awvalid;
    logic              awready;
    logic [ADDR_W-1:0] awaddr;
    logic [2:0]        awprot;
    logic              wvalid;
    logic              wready;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
    logic              bvalid;
    logic              bready;
    logic [1:0]        bresp;
    logic              arvalid;
    logic              arready;
    logic [ADDR_W-1:0] araddr;
    logic [2:0]        arprot;
    logic              rvalid;
    logic              rready;
    logic [31:0]       rdata;
    logic [1:0]        rresp;

    modport master (
        output awvalid, awaddr, awprot,
        output wvalid, wdata, wstrb,
        output bready,
        output arvalid, araddr, arprot,
        output rready,
        input  awready, wready,
        input  bvalid, bresp,
        input  arready,
        input  rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, awprot,
        input  wvalid, wdata, wstrb,
        input  bready,
        input  arvalid, araddr, arprot,
        input  rready,
        output awready, wready,
        output bvalid, bresp,
        output arready,
        output rvalid, rdata, rresp
    );
endinterface

// File: rtl/led_regs_axil_arbiter.sv
// Round-robin arbiter sharing the LED register AXI-Lite port
// between NUM_REQ single-word command requesters.
module led_regs_axil_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 21
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        cmd_valid,
    output logic [NUM_REQ-1:0]        cmd_ready,
    input  logic [NUM_REQ-1:0]        cmd_we,
    input  logic [NUM_REQ*ADDR_W-1:0] cmd_addr,
    input  logic [NUM_REQ*32-1:0]     cmd_wdata,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [31:0]               rsp_rdata,
    output logic                      rsp_err,
    output logic                      busy,
    led_regs_axil_arbiter_if.master   m_axil
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_RESP,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   rr_q, rr_d;
    logic [IDX_W-1:0]   gnt_q, gnt_d;
    logic [IDX_W-1:0]   win, win_nxt;
    logic               found;
    int                 j;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               err_q, err_d;
    logic               awvalid_q, awvalid_d;
    logic               wvalid_q, wvalid_d;
    logic               arvalid_q, arvalid_d;
    logic               bready_q, bready_d;
    logic               rready_q, rready_d;
    logic               aw_fin, w_fin;

    logic [ADDR_W-1:0]  addr_a  [NUM_REQ];
    logic [31:0]        wdata_a [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign addr_a[g]  = cmd_addr[g*ADDR_W +: ADDR_W];
        assign wdata_a[g] = cmd_wdata[g*32 +: 32];
    end

    // Search starts at rr_ptr and wraps, so the last winner goes last.
    always_comb begin
        found = 1'b0;
        win   = '0;
        j     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = int'(rr_q) + k;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (!found && cmd_valid[IDX_W'(j)]) begin
                found = 1'b1;
                win   = IDX_W'(j);
            end
        end
    end

    assign win_nxt = (win == IDX_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;

    always_comb begin
        cmd_ready = '0;
        if (rst && state_q == IDLE && found) cmd_ready[win] = 1'b1;
    end

    always_comb begin
        rsp_valid = '0;
        if (state_q == DONE) rsp_valid[gnt_q] = 1'b1;
    end

    assign busy      = (state_q != IDLE);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

    assign m_axil.awvalid = awvalid_q;
    assign m_axil.awaddr  = addr_q & ~ADDR_W'(3);
    assign m_axil.awprot  = 3'b000;
    assign m_axil.wvalid  = wvalid_q;
    assign m_axil.wdata   = wdata_q;
    assign m_axil.wstrb   = {4{wvalid_q}};
    assign m_axil.bready  = bready_q;
    assign m_axil.arvalid = arvalid_q;
    assign m_axil.araddr  = addr_q & ~ADDR_W'(3);
    assign m_axil.arprot  = 3'b000;
    assign m_axil.rready  = rready_q;

    assign aw_fin = !awvalid_q || m_axil.awready;
    assign w_fin  = !wvalid_q || m_axil.wready;

    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        gnt_d     = gnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        arvalid_d = arvalid_q;
        bready_d  = bready_q;
        rready_d  = rready_q;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    gnt_d   = win;
                    rr_d    = win_nxt;
                    addr_d  = addr_a[win];
                    wdata_d = wdata_a[win];
                    if (cmd_we[win]) begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = WR_REQ;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = RD_REQ;
                    end
                end
            end
            WR_REQ: begin
                // AW and W complete independently, possibly in one cycle.
                if (m_axil.awready) awvalid_d = 1'b0;
                if (m_axil.wready)  wvalid_d  = 1'b0;
                if (aw_fin && w_fin) begin
                    awvalid_d = 1'b0;
                    wvalid_d  = 1'b0;
                    bready_d  = 1'b1;
                    state_d   = WR_RESP;
                end
            end
            WR_RESP: begin
                if (m_axil.bvalid) begin
                    bready_d = 1'b0;
                    rdata_d  = '0;
                    err_d    = |(m_axil.bresp & 2'b10);
                    state_d  = DONE;
                end
            end
            RD_REQ: begin
                if (m_axil.arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RD_RESP;
                end
            end
            RD_RESP: begin
                if (m_axil.rvalid) begin
                    rready_d = 1'b0;
                    rdata_d  = m_axil.rdata;
                    err_d    = |(m_axil.rresp & 2'b10);
                    state_d  = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            rr_q      <= '0;
            gnt_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            arvalid_q <= 1'b0;
            bready_q  <= 1'b0;
            rready_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            gnt_q     <= gnt_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            arvalid_q <= arvalid_d;
            bready_q  <= bready_d;
            rready_q  <= rready_d;
        end
    end

endmodule

// File: tb/tb_led_regs_axil_arbiter.sv
// Scoreboard bench for led_regs_axil_arbiter with an AXI-Lite
// slave model offering per-channel stalls and error injection.
module tb_led_regs_axil_arbiter;

    localparam int NUM_REQ = 2;
    localparam int ADDR_W  = 21;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [NUM_REQ-1:0]        cmd_valid = '0;
    logic [NUM_REQ-1:0]        cmd_we    = '0;
    logic [NUM_REQ*ADDR_W-1:0] cmd_addr  = '0;
    logic [NUM_REQ*32-1:0]     cmd_wdata = '0;
    logic [NUM_REQ-1:0]        cmd_ready;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [31:0]               rsp_rdata;
    logic                      rsp_err;
    logic                      busy;

    led_regs_axil_arbiter_if #(.ADDR_W(ADDR_W)) axil ();

    led_regs_axil_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_we    (cmd_we),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .m_axil    (axil)
    );

    typedef struct {
        int          id;
        logic [31:0] rdata;
        logic        err;
        int          acc;
        bit          lat;
    } exp_t;

    exp_t sb[$];
    int   acc_log[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   rsp_n = 0;
    int   last_acc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Slave model
    int          aw_delay = 0;
    int          w_delay = 0;
    bit          r_hold = 0;
    bit          r_pend;
    logic [1:0]  rresp_val = 2'b00;
    logic [1:0]  bresp_val = 2'b00;
    int          aw_cnt, w_cnt;
    bit          aw_got, w_got;
    logic [ADDR_W-1:0] aw_a;
    logic [31:0] w_d;
    int          aw_hs_n = 0, w_hs_n = 0;
    int          aw_hs_cyc = 0, w_hs_cyc = 0;
    int          bad_n = 0;
    int          bready_early = 0;
    logic [31:0] mem [64];
    logic [ADDR_W-1:0] wa;
    logic [31:0] wd;
    bit          na, nw;

    assign axil.awready = axil.awvalid && (aw_cnt >= aw_delay);
    assign axil.wready  = axil.wvalid && (w_cnt >= w_delay);
    assign axil.arready = axil.arvalid;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            aw_cnt      <= 0;
            w_cnt       <= 0;
            aw_got      <= 0;
            w_got       <= 0;
            r_pend      <= 0;
            axil.bvalid <= 1'b0;
            axil.bresp  <= 2'b00;
            axil.rvalid <= 1'b0;
            axil.rresp  <= 2'b00;
            axil.rdata  <= '0;
        end else begin
            na = aw_got;
            nw = w_got;
            wa = aw_a;
            wd = w_d;
            if (axil.awvalid) begin
                if (axil.awready) begin
                    na = 1;
                    wa = axil.awaddr;
                    aw_cnt <= 0;
                    aw_hs_n++;
                    aw_hs_cyc <= cyc;
                    if (axil.awaddr[1:0] != 2'b00 || axil.awprot != 3'b000)
                        bad_n++;
                end else begin
                    aw_cnt <= aw_cnt + 1;
                end
            end
            if (axil.wvalid) begin
                if (axil.wready) begin
                    nw = 1;
                    wd = axil.wdata;
                    w_cnt <= 0;
                    w_hs_n++;
                    w_hs_cyc <= cyc;
                    if (axil.wstrb != 4'hF) bad_n++;
                end else begin
                    w_cnt <= w_cnt + 1;
                end
            end
            if (na && nw && !axil.bvalid) begin
                axil.bvalid <= 1'b1;
                axil.bresp  <= bresp_val;
                mem[wa[7:2]] <= wd;
                na = 0;
                nw = 0;
            end
            aw_got <= na;
            w_got  <= nw;
            aw_a   <= wa;
            w_d    <= wd;
            if (axil.bvalid && axil.bready) axil.bvalid <= 1'b0;
            if (axil.arvalid && axil.arready) begin
                axil.rdata <= mem[axil.araddr[7:2]];
                axil.rresp <= rresp_val;
                if (axil.araddr[1:0] != 2'b00 || axil.arprot != 3'b000)
                    bad_n++;
                if (r_hold) r_pend <= 1;
                else axil.rvalid <= 1'b1;
            end else if (r_pend && !r_hold) begin
                axil.rvalid <= 1'b1;
                r_pend <= 0;
            end
            if (axil.rvalid && axil.rready) axil.rvalid <= 1'b0;
        end
    end

    always @(negedge clk)
        if (rst && axil.bready && (axil.awvalid || axil.wvalid))
            bready_early++;

    // Response monitor
    always @(negedge clk) begin
        if (rst && |rsp_valid) begin
            exp_t e;
            rsp_n++;
            if (sb.size() == 0) begin
                chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("rsp_id", 32'(rsp_valid), 32'd1 << e.id);
                chk("rsp_rdata", rsp_rdata, e.rdata);
                chk("rsp_err", 32'(rsp_err), 32'(e.err));
                if (e.lat) chk("rsp_latency", cyc - e.acc, 3);
            end
        end
    end

    task automatic issue(input int id, input bit we,
                         input logic [ADDR_W-1:0] a, input logic [31:0] d,
                         input logic [31:0] er, input bit ee,
                         input bit push, input bit lat);
        bit   ok = 0;
        exp_t e;
        cmd_we[id] = we;
        cmd_addr[id*ADDR_W +: ADDR_W] = a;
        cmd_wdata[id*32 +: 32] = d;
        cmd_valid[id] = 1'b1;
        for (int n = 0; n < 300 && !ok; n++) begin
            #1;
            if (cmd_ready[id]) ok = 1;
            else @(negedge clk);
        end
        if (ok) begin
            e.id = id; e.rdata = er; e.err = ee; e.acc = cyc; e.lat = lat;
            if (push) sb.push_back(e);
            acc_log.push_back(id);
            last_acc = cyc;
            @(posedge clk);
            #1;
        end else begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: req %0d got no cmd_ready expected 1", id);
        end
        cmd_valid[id] = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (sb.size() == 0 && !busy) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: pending %0d expected 0", sb.size());
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int aw_b, w_b, rsp_b;
    bit seen;

    initial begin
        repeat (3) @(negedge clk);
        #1;
        chk("reset_rdata", rsp_rdata, 32'd0);
        chk("reset_ctrl", 32'({cmd_ready, rsp_valid, rsp_err, busy,
                               axil.awvalid, axil.wvalid, axil.arvalid,
                               axil.bready, axil.rready}), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // single write, zero-wait slave
        aw_b = aw_hs_n; w_b = w_hs_n;
        issue(0, 1, 21'h000, 32'hA5, 32'h0, 0, 1, 1);
        wait_idle();
        chk("aw_hs_cycle", aw_hs_cyc, last_acc + 1);
        chk("w_hs_cycle", w_hs_cyc, last_acc + 1);
        chk("led_mem0", mem[0], 32'hA5);
        chk("t1_aw_count", aw_hs_n - aw_b, 1);

        // read-back by requester 1
        issue(1, 0, 21'h000, 32'h0, 32'h0000_00A5, 0, 1, 1);
        wait_idle();

        // round robin with both requesters continuously valid
        acc_log.delete();
        fork
            begin
                for (int k = 0; k < 4; k++)
                    issue(0, 1, ADDR_W'(32'h10 + 4 * k), 32'h100 + k,
                          32'h0, 0, 1, 0);
            end
            begin
                for (int k = 0; k < 4; k++)
                    issue(1, 1, ADDR_W'(32'h20 + 4 * k), 32'h200 + k,
                          32'h0, 0, 1, 0);
            end
        join
        wait_idle();
        chk("rr_count", acc_log.size(), 8);
        foreach (acc_log[i]) chk("rr_order", acc_log[i], i % 2);
        chk("rr_mem_r1k3", mem[11], 32'h203);

        // skewed AW / W handshakes
        aw_b = aw_hs_n; w_b = w_hs_n; rsp_b = rsp_n;
        aw_delay = 3;
        issue(0, 1, 21'h004, 32'h1234, 32'h0, 0, 1, 0);
        wait_idle();
        chk("skew_aw_count", aw_hs_n - aw_b, 1);
        chk("skew_w_count", w_hs_n - w_b, 1);
        chk("skew_rsp_count", rsp_n - rsp_b, 1);
        aw_delay = 0; w_delay = 3;
        issue(1, 1, 21'h006, 32'h5678, 32'h0, 0, 1, 0);
        wait_idle();
        w_delay = 0;
        chk("skew2_aw_count", aw_hs_n - aw_b, 2);
        chk("skew2_w_count", w_hs_n - w_b, 2);
        chk("skew2_rsp_count", rsp_n - rsp_b, 2);
        issue(0, 0, 21'h005, 32'h0, 32'h5678, 0, 1, 1);
        wait_idle();
        chk("bready_early", bready_early, 0);

        // read error response
        rresp_val = 2'b10;
        issue(1, 0, 21'h000, 32'h0, 32'h0000_00A5, 1, 1, 0);
        wait_idle();
        rresp_val = 2'b00;

        // reset in the middle of RD_RESP
        r_hold = 1;
        issue(0, 0, 21'h004, 32'h0, 32'h0, 0, 0, 0);
        seen = 0;
        for (int n = 0; n < 50 && !seen; n++) begin
            @(negedge clk);
            if (axil.rready) seen = 1;
        end
        chk("reach_rd_resp", 32'(seen), 32'd1);
        rsp_b = rsp_n;
        #2 rst = 1'b0;
        cmd_we = '0;
        cmd_valid = '1;
        #1;
        chk("rst_mid_ctrl", 32'({cmd_ready, rsp_valid, busy,
                                 axil.awvalid, axil.wvalid, axil.arvalid,
                                 axil.bready, axil.rready}), 32'd0);
        repeat (2) @(negedge clk);
        cmd_valid = '0;
        r_hold = 0;
        rst = 1'b1;
        repeat (4) @(negedge clk);
        chk("no_rsp_after_rst", rsp_n - rsp_b, 0);
        chk("idle_after_rst", 32'(busy), 32'd0);
        acc_log.delete();
        fork
            issue(0, 0, 21'h000, 32'h0, 32'h0000_00A5, 0, 1, 1);
            issue(1, 0, 21'h004, 32'h0, 32'h0000_5678, 0, 1, 0);
        join
        wait_idle();
        chk("grant_after_rst", acc_log.size() > 0 ? acc_log[0] : -1, 0);

        chk("axi_fields_bad", bad_n, 0);
        chk("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
